// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control, detects load-use
// hazards (one-cycle bubble), bypasses same-cycle write-back and counts stall cycles.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] extended_bits,
  input  logic                  RegWrite,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemtoReg,
  input  logic                  RegDst,
  input  logic                  ALUSrc,
  input  logic                  Branch,
  input  logic [1:0]            ALUOp,
  input  logic                  flush,
  input  logic                  wb_RegWrite,
  input  logic [4:0]            wb_write_register,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_read_data1,
  output logic [DATA_WIDTH-1:0] ex_read_data2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_write_register,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_MemtoReg,
  output logic                  ex_ALUSrc,
  output logic                  ex_Branch,
  output logic [1:0]            ex_ALUOp,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]            rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic                  regwrite_q, regwrite_d, memread_q, memread_d;
  logic                  memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;
  logic                  alusrc_q, alusrc_d, branch_q, branch_d;
  logic [1:0]            aluop_q, aluop_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [4:0] id_rs, id_rt, id_rd;
  logic       hazard, bubble, byp1, byp2;
  logic       unused_instr_bits;

  assign id_rs = instruction[25:21];
  assign id_rt = instruction[20:16];
  assign id_rd = instruction[15:11];
  assign unused_instr_bits = ^{instruction[31:26], instruction[10:0]};

  // rt is compared even for I-type consumers; the occasional extra bubble is accepted.
  assign hazard = id_valid & valid_q & memread_q & (rt_q != 5'd0) &
                  ((rt_q == id_rs) | (rt_q == id_rt));
  assign stall  = hazard;
  assign bubble = flush | hazard;

  assign byp1 = WB_BYPASS & wb_RegWrite & (wb_write_register != 5'd0) &
                (wb_write_register == id_rs);
  assign byp2 = WB_BYPASS & wb_RegWrite & (wb_write_register != 5'd0) &
                (wb_write_register == id_rt);

  always_comb begin
    valid_d    = 1'b0;
    rd1_d      = '0;
    rd2_d      = '0;
    imm_d      = '0;
    rs_d       = '0;
    rt_d       = '0;
    wr_d       = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    alusrc_d   = 1'b0;
    branch_d   = 1'b0;
    aluop_d    = 2'b00;
    if (!bubble) begin
      valid_d    = id_valid;
      rd1_d      = byp1 ? wb_write_data : read_data1;
      rd2_d      = byp2 ? wb_write_data : read_data2;
      imm_d      = extended_bits;
      rs_d       = id_rs;
      rt_d       = id_rt;
      wr_d       = RegDst ? id_rd : id_rt;
      // An empty ID slot must never leak side-effecting control into EX.
      regwrite_d = id_valid & RegWrite;
      memread_d  = id_valid & MemRead;
      memwrite_d = id_valid & MemWrite;
      memtoreg_d = id_valid & MemtoReg;
      alusrc_d   = id_valid & ALUSrc;
      branch_d   = id_valid & Branch;
      aluop_d    = id_valid ? ALUOp : 2'b00;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wr_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= 2'b00;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wr_q       <= wr_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      branch_q   <= branch_d;
      aluop_q    <= aluop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid          = valid_q;
  assign ex_read_data1     = rd1_q;
  assign ex_read_data2     = rd2_q;
  assign ex_imm            = imm_q;
  assign ex_rs             = rs_q;
  assign ex_rt             = rt_q;
  assign ex_write_register = wr_q;
  assign ex_RegWrite       = regwrite_q;
  assign ex_MemRead        = memread_q;
  assign ex_MemWrite       = memwrite_q;
  assign ex_MemtoReg       = memtoreg_q;
  assign ex_ALUSrc         = alusrc_q;
  assign ex_Branch         = branch_q;
  assign ex_ALUOp          = aluop_q;
  assign stall_count       = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, randomized run against a
// behavioural EX-slot model, and hand sequences for reset-in-stall and counter saturation.
module tb_id_ex_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid, RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, Branch;
  logic [31:0] instruction, read_data1, read_data2, extended_bits, wb_write_data;
  logic [1:0]  ALUOp;
  logic        flush, wb_RegWrite;
  logic [4:0]  wb_write_register;

  logic        stall, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_write_register;
  logic [1:0]  ex_ALUOp;
  logic [15:0] stall_count;

  logic        s_stall, s_ex_valid;
  logic [1:0]  s_stall_count;
  logic        unused_s_rw, unused_s_mr, unused_s_mw, unused_s_m2r, unused_s_as, unused_s_br;
  logic [31:0] unused_s_d1, unused_s_d2, unused_s_imm;
  logic [4:0]  unused_s_rs, unused_s_rt, unused_s_wr;
  logic [1:0]  unused_s_aluop;

  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instruction(instruction),
    .read_data1(read_data1), .read_data2(read_data2), .extended_bits(extended_bits),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .ALUOp(ALUOp), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
    .stall(stall), .ex_valid(ex_valid), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_register(ex_write_register),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .stall_count(stall_count));

  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(2), .WB_BYPASS(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instruction(instruction),
    .read_data1(read_data1), .read_data2(read_data2), .extended_bits(extended_bits),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Branch(Branch), .ALUOp(ALUOp), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_read_data1(unused_s_d1), .ex_read_data2(unused_s_d2),
    .ex_imm(unused_s_imm), .ex_rs(unused_s_rs), .ex_rt(unused_s_rt), .ex_write_register(unused_s_wr),
    .ex_RegWrite(unused_s_rw), .ex_MemRead(unused_s_mr), .ex_MemWrite(unused_s_mw),
    .ex_MemtoReg(unused_s_m2r), .ex_ALUSrc(unused_s_as), .ex_Branch(unused_s_br),
    .ex_ALUOp(unused_s_aluop), .stall_count(s_stall_count));

  // control bit order: {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, Branch}
  localparam logic [6:0] CTL_ADD = 7'b1000100;
  localparam logic [6:0] CTL_LW  = 7'b1101010;

  typedef struct {
    logic        id_valid;
    logic [31:0] instr, rd1, rd2, imm;
    logic [6:0]  ctl;
    logic [1:0]  aluop;
    logic        flush, wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
  } in_t;

  typedef struct {
    in_t         in;
    logic        e_stall, e_valid;
    logic [31:0] e_rd1, e_rd2;
    logic [4:0]  e_wr;
    logic        e_rw, e_mr;
    int          e_cnt;
  } vec_t;

  // Contents of the EX slot as the instruction set sees it.
  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, wr;
    logic [31:0] d1, d2, imm;
    logic        rw, mr, mw, m2r, asrc, br;
    logic [1:0]  aluop;
  } ex_t;

  ex_t m;
  int  m_cnt, m_cnt2;
  int  n_vec = 0;
  int  n_err = 0;
  int  n_step = 0;

  function automatic logic [31:0] rtype(int rs, int rt, int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] lw(int rt, int base);
    return {6'h23, 5'(base), 5'(rt), 16'd0};
  endfunction

  function automatic vec_t mkv(logic idv, logic [31:0] instr, logic [31:0] rd1, logic [31:0] rd2,
                               logic [6:0] ctl, logic fl, logic we, logic [4:0] wreg,
                               logic [31:0] wdata, logic es, logic ev, logic [31:0] e1,
                               logic [31:0] e2, logic [4:0] ew, logic erw, logic emr, int ec);
    vec_t v;
    v.in.id_valid = idv; v.in.instr = instr; v.in.rd1 = rd1; v.in.rd2 = rd2;
    v.in.imm = 32'h0000_0010; v.in.ctl = ctl; v.in.aluop = (ctl == CTL_LW) ? 2'b00 : 2'b10;
    v.in.flush = fl; v.in.wb_we = we; v.in.wb_reg = wreg; v.in.wb_data = wdata;
    v.e_stall = es; v.e_valid = ev; v.e_rd1 = e1; v.e_rd2 = e2; v.e_wr = ew;
    v.e_rw = erw; v.e_mr = emr; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic model_stall(in_t v);
    logic [4:0] rs, rt;
    rs = v.instr[25:21];
    rt = v.instr[20:16];
    return v.id_valid && m.valid && m.mr && (m.rt != 5'd0) && (m.rt == rs || m.rt == rt);
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_step(in_t v);
    logic hz;
    logic [4:0] rs, rt;
    hz = model_stall(v);
    rs = v.instr[25:21];
    rt = v.instr[20:16];
    if (hz && !v.flush) begin
      m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    if (v.flush || hz) begin
      m = '{default: '0};
    end else begin
      m.valid = v.id_valid;
      m.rs = rs;
      m.rt = rt;
      m.wr = v.ctl[2] ? v.instr[15:11] : rt;
      m.d1 = (v.wb_we && v.wb_reg != 0 && v.wb_reg == rs) ? v.wb_data : v.rd1;
      m.d2 = (v.wb_we && v.wb_reg != 0 && v.wb_reg == rt) ? v.wb_data : v.rd2;
      m.imm = v.imm;
      m.rw = v.id_valid && v.ctl[6];
      m.mr = v.id_valid && v.ctl[5];
      m.mw = v.id_valid && v.ctl[4];
      m.m2r = v.id_valid && v.ctl[3];
      m.asrc = v.id_valid && v.ctl[1];
      m.br = v.id_valid && v.ctl[0];
      m.aluop = v.id_valid ? v.aluop : 2'b00;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, n_step, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    id_valid = v.id_valid; instruction = v.instr; read_data1 = v.rd1; read_data2 = v.rd2;
    extended_bits = v.imm;
    {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, Branch} = v.ctl;
    ALUOp = v.aluop; flush = v.flush; wb_RegWrite = v.wb_we;
    wb_write_register = v.wb_reg; wb_write_data = v.wb_data;
  endtask

  // One clock of traffic: returns the sampled stall and the model's prediction of it.
  task automatic apply(in_t v, output logic st_seen, output logic st_pred);
    @(negedge clk);
    drive(v);
    #1;
    st_seen = stall;
    st_pred = model_stall(v);
    @(posedge clk);
    model_step(v);
    #1;
    n_step++;
    $display("step %0d: idv=%0b instr=%08h flush=%0b wb=%0b/r%0d stall=%0b -> ex_valid=%0b d1=%08h d2=%08h wr=%0d cnt=%0d",
             n_step, v.id_valid, v.instr, v.flush, v.wb_we, v.wb_reg, st_seen,
             ex_valid, ex_read_data1, ex_read_data2, ex_write_register, stall_count);
  endtask

  task automatic check_model();
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("ex_read_data1", ex_read_data1, m.d1);
    chk("ex_read_data2", ex_read_data2, m.d2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs", 32'(ex_rs), 32'(m.rs));
    chk("ex_rt", 32'(ex_rt), 32'(m.rt));
    chk("ex_write_register", 32'(ex_write_register), 32'(m.wr));
    chk("ex_ctl", 32'({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch, ex_ALUOp}),
        32'({m.rw, m.mr, m.mw, m.m2r, m.asrc, m.br, m.aluop}));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
    chk("stall_count_sat", 32'(s_stall_count), 32'(m_cnt2));
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom % 4)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd8;
      default: return 5'($urandom % 32);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    in_t  v;
    logic st_seen, st_pred;

    drive('{default: '0});
    model_reset();

    #2;
    chk("reset_async_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_async_stall_count", 32'(stall_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    //            idv instr               rd1           rd2           ctl     fl we wreg  wdata         stall valid e_rd1         e_rd2         wr rw mr cnt
    tbl.push_back(mkv(1, rtype(1, 2, 3),  32'd5,        32'd7,        CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 1, 32'd5,        32'd7,        3, 1, 0, 0));
    tbl.push_back(mkv(1, lw(8, 29),       32'd100,      32'd0,        CTL_LW,  0, 0, 5'd0, 32'd0,        0, 1, 32'd100,      32'd0,        8, 1, 1, 0));
    tbl.push_back(mkv(1, rtype(8, 1, 9),  32'd11,       32'd22,       CTL_ADD, 0, 0, 5'd0, 32'd0,        1, 0, 32'd0,        32'd0,        0, 0, 0, 1));
    tbl.push_back(mkv(1, rtype(8, 1, 9),  32'd11,       32'd22,       CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 1, 32'd11,       32'd22,       9, 1, 0, 1));
    tbl.push_back(mkv(1, lw(8, 29),       32'd100,      32'd0,        CTL_LW,  0, 0, 5'd0, 32'd0,        0, 1, 32'd100,      32'd0,        8, 1, 1, 1));
    tbl.push_back(mkv(1, rtype(1, 2, 9),  32'd5,        32'd7,        CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 1, 32'd5,        32'd7,        9, 1, 0, 1));
    tbl.push_back(mkv(1, lw(0, 29),       32'd100,      32'd0,        CTL_LW,  0, 0, 5'd0, 32'd0,        0, 1, 32'd100,      32'd0,        0, 1, 1, 1));
    tbl.push_back(mkv(1, rtype(0, 0, 9),  32'd0,        32'd0,        CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 1, 32'd0,        32'd0,        9, 1, 0, 1));
    tbl.push_back(mkv(1, lw(8, 29),       32'd100,      32'd0,        CTL_LW,  0, 0, 5'd0, 32'd0,        0, 1, 32'd100,      32'd0,        8, 1, 1, 1));
    tbl.push_back(mkv(1, rtype(8, 1, 9),  32'd11,       32'd22,       CTL_ADD, 1, 0, 5'd0, 32'd0,        1, 0, 32'd0,        32'd0,        0, 0, 0, 1));
    tbl.push_back(mkv(1, rtype(8, 1, 9),  32'd11,       32'd22,       CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 1, 32'd11,       32'd22,       9, 1, 0, 1));
    tbl.push_back(mkv(1, rtype(4, 6, 5),  32'd1,        32'd2,        CTL_ADD, 0, 1, 5'd4, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'd2,        5, 1, 0, 1));
    tbl.push_back(mkv(1, rtype(4, 6, 5),  32'd1,        32'd2,        CTL_ADD, 0, 1, 5'd0, 32'hDEADBEEF, 0, 1, 32'd1,        32'd2,        5, 1, 0, 1));
    tbl.push_back(mkv(1, rtype(4, 6, 5),  32'd1,        32'd2,        CTL_ADD, 0, 1, 5'd6, 32'hCAFEF00D, 0, 1, 32'd1,        32'hCAFEF00D, 5, 1, 0, 1));
    tbl.push_back(mkv(0, rtype(1, 2, 7),  32'd3,        32'd4,        CTL_ADD, 0, 0, 5'd0, 32'd0,        0, 0, 32'd3,        32'd4,        7, 0, 0, 1));
    tbl.push_back(mkv(1, rtype(4, 6, 5),  32'd1,        32'd2,        CTL_ADD, 0, 0, 5'd4, 32'h12345678, 0, 1, 32'd1,        32'd2,        5, 1, 0, 1));
    tbl.push_back(mkv(1, rtype(4, 6, 5),  32'd1,        32'd2,        CTL_ADD, 1, 0, 5'd0, 32'd0,        0, 0, 32'd0,        32'd0,        0, 0, 0, 1));

    foreach (tbl[i]) begin
      apply(tbl[i].in, st_seen, st_pred);
      chk("tbl_stall", 32'(st_seen), 32'(tbl[i].e_stall));
      chk("tbl_ex_valid", 32'(ex_valid), 32'(tbl[i].e_valid));
      chk("tbl_ex_read_data1", ex_read_data1, tbl[i].e_rd1);
      chk("tbl_ex_read_data2", ex_read_data2, tbl[i].e_rd2);
      chk("tbl_ex_write_register", 32'(ex_write_register), 32'(tbl[i].e_wr));
      chk("tbl_ex_RegWrite", 32'(ex_RegWrite), 32'(tbl[i].e_rw));
      chk("tbl_ex_MemRead", 32'(ex_MemRead), 32'(tbl[i].e_mr));
      chk("tbl_stall_count", 32'(stall_count), 32'(tbl[i].e_cnt));
      chk("tbl_stall_count_sat", 32'(s_stall_count), 32'((tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt));
    end

    for (int i = 0; i < 300; i++) begin
      v.id_valid = ($urandom % 8) != 0;
      if ($urandom % 3 == 0) begin
        v.instr = lw(int'(pick_reg()), int'(pick_reg()));
        v.ctl   = CTL_LW;
      end else begin
        v.instr = rtype(int'(pick_reg()), int'(pick_reg()), int'($urandom % 32));
        v.ctl   = 7'($urandom);
      end
      v.aluop   = 2'($urandom);
      v.rd1     = $urandom;
      v.rd2     = $urandom;
      v.imm     = $urandom;
      v.flush   = ($urandom % 8) == 0;
      v.wb_we   = 1'($urandom);
      v.wb_reg  = pick_reg();
      v.wb_data = $urandom;
      apply(v, st_seen, st_pred);
      chk("rnd_stall", 32'(st_seen), 32'(st_pred));
      check_model();
    end

    // Reset asserted while a load-use stall is pending.
    v = tbl[1].in;
    apply(v, st_seen, st_pred);
    @(negedge clk);
    drive(tbl[2].in);
    #1;
    chk("pre_reset_stall", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_stall", 32'(stall), 32'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Five load-use pairs: the 2-bit counter must climb to 3 and stick.
    for (int r = 1; r <= 5; r++) begin
      apply(tbl[1].in, st_seen, st_pred);
      apply(tbl[2].in, st_seen, st_pred);
      chk("sat_stall", 32'(st_seen), 32'd1);
      apply(tbl[2].in, st_seen, st_pred);
      chk("sat_restall", 32'(st_seen), 32'd0);
      chk("sat_count_sat", 32'(s_stall_count), 32'((r > 3) ? 3 : r));
      chk("sat_count_wide", 32'(stall_count), 32'(r));
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register placed directly downstream of the register-file/decode stage.
- Captures read operands, the sign-extended immediate, register fields and decoded control each cycle.
- Detects load-use hazards and stalls upstream for one cycle while inserting a bubble.
- Bypasses a same-cycle write-back into the captured operands, tolerates branch flush, and counts stall cycles for performance analysis.

Parameters:
- DATA_WIDTH, 32, width of operands and immediate.
- CNT_WIDTH, 16, width of the saturating stall counter.
- WB_BYPASS, 1, 1 = bypass write-back data into captured operands; 0 = capture raw read data.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- instruction  in  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11]
- read_data1  in  DATA_WIDTH  register-file port 1 (rs)
- read_data2  in  DATA_WIDTH  register-file port 2 (rt)
- extended_bits  in  DATA_WIDTH  sign-extended immediate
- RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, Branch  in  1 each  decoded control
- ALUOp  in  2  decoded ALU class
- flush  in  1  taken branch/jump resolved downstream; kill the ID instruction
- wb_RegWrite  in  1  write-back enable (the same signal drives the register file)
- wb_write_register  in  5  write-back destination
- wb_write_data  in  DATA_WIDTH  write-back data
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_read_data1, ex_read_data2, ex_imm  out  DATA_WIDTH  registered operands and immediate
- ex_rs, ex_rt  out  5  registered source fields (for forwarding)
- ex_write_register  out  5  RegDst ? rd : rt, resolved at capture
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch  out  1 each  registered control
- ex_ALUOp  out  2  registered ALU class
- stall_count  out  CNT_WIDTH  saturating count of cycles with stall=1

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including ex_valid and stall_count. stall therefore evaluates to 0.
- Hazard condition, combinational:
  - stall = id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == instruction[25:21]) | (ex_rt == instruction[20:16])).
  - rt is compared unconditionally; a conservative extra stall on I-type instructions is accepted.
- Per rising edge, in priority order:
  1. flush=1 → load bubble: ex_valid=0, all ex_ control=0, ex_ALUOp=0. Data fields are don't-care; clear them to 0.
  2. else stall=1 → load bubble, identical to case 1. Upstream holds, so the same instruction is re-presented next cycle and stall deasserts because the EX stage now holds the bubble.
  3. else → capture all inputs. ex_valid=id_valid. When id_valid=0, all ex_ control is forced to 0.
- Write-back bypass (WB_BYPASS=1), applied per operand at capture:
  - If wb_RegWrite & wb_write_register != 0 & wb_write_register == rs, then ex_read_data1 = wb_write_data.
  - The same rule with rt selects ex_read_data2.
  - Register 0 is never bypassed.
- ex_write_register = RegDst ? instruction[15:11] : instruction[20:16].
- stall_count increments by 1 on each edge where stall=1 and flush=0, and holds at all-ones (saturates, no wrap).
- Latency is 1 cycle from ID inputs to ex_ outputs. A load-use pair costs exactly one bubble.
- flush and stall in the same cycle: flush wins and the counter does not increment. stall remains asserted combinationally that cycle; upstream treats flush as dominant.
- Reset asserted mid-stall: outputs clear immediately and stall drops to 0 combinationally.

Test Plan:
- Reset → all ex_ outputs 0, stall=0, stall_count=0. Release, then id_valid=1 with add $3,$1,$2 (rd=3, RegDst=1, read_data1=5, read_data2=7) → next cycle ex_read_data1=5, ex_read_data2=7, ex_write_register=3, ex_RegWrite=1, ex_valid=1.
- lw $8,0($29) in EX (ex_MemRead=1, ex_rt=8), then ID holds add $9,$8,$1 → stall=1. Next edge: bubble (ex_valid=0, ex_RegWrite=0), stall_count=1. Following cycle: stall=0 and the add is captured.
- Same load in EX with ID add $9,$1,$2 → stall=0, no bubble.
- lw with rt=0 in EX, ID reads $0 → stall=0.
- flush=1 coincident with a load-use stall → bubble, stall_count unchanged.
- ID reads rs=$4 (read_data1=1) while wb_RegWrite=1, wb_write_register=4, wb_write_data=0xDEADBEEF → ex_read_data1=0xDEADBEEF. With wb_write_register=0 → raw read_data1 is kept.
- CNT_WIDTH=2, hold a load-use hazard over 5 consecutive loads → stall_count reaches 3 and stays at 3.
